// File: rtl/vga_pkg.sv
// Constants shared by the frame buffer writer and the display read side,
// plus the writer state encoding.
package vga_pkg;

    localparam int IMG_W       = 640;
    localparam int IMG_H       = 480;
    localparam int ADDR_W      = 20;
    localparam int DATA_W      = 8;

    // Both sides map pixel (x, y) to buffer address x*IMG_H + y.
    localparam int H_ACT_START = 144;
    localparam int H_ACT_END   = 783;
    localparam int V_ACT_START = 35;
    localparam int V_ACT_END   = 514;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } wr_state_e;

endpackage

// File: rtl/frame_buffer_writer_if.sv
// Pixel stream in, frame buffer write port out.
interface frame_buffer_writer_if #(
    parameter int ADDR_W = vga_pkg::ADDR_W,
    parameter int DATA_W = vga_pkg::DATA_W
) ();

    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_last;
    logic              s_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport slave (
        input  s_valid, s_data, s_last,
        output s_ready, wr_en, wr_addr, wr_data
    );

    modport master (
        output s_valid, s_data, s_last,
        input  s_ready, wr_en, wr_addr, wr_data
    );

endinterface

// File: rtl/raster_addr_gen.sv
// Raster x/y counters with an incremental column-major address (x*IMG_H + y).
module raster_addr_gen #(
    parameter int IMG_W  = vga_pkg::IMG_W,
    parameter int IMG_H  = vga_pkg::IMG_H,
    parameter int ADDR_W = vga_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              step,
    output logic [ADDR_W-1:0] addr,
    output logic              last_pixel
);

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam logic [XW-1:0]     X_MAX     = XW'(IMG_W - 1);
    localparam logic [YW-1:0]     Y_MAX     = YW'(IMG_H - 1);
    localparam logic [ADDR_W-1:0] COL_STRIDE = ADDR_W'(IMG_H);

    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    // Next position: step right by one column, or wrap to the next row.
    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        addr_d = addr_q;
        if (clear) begin
            x_d    = '0;
            y_d    = '0;
            addr_d = '0;
        end else if (step) begin
            if (x_q != X_MAX) begin
                x_d    = x_q + XW'(1);
                addr_d = addr_q + COL_STRIDE;
            end else begin
                x_d    = '0;
                y_d    = y_q + YW'(1);
                addr_d = ADDR_W'(y_q) + ADDR_W'(1);
            end
        end else begin
            x_d    = x_q;
        end
    end

    // Position registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_q    <= '0;
            y_q    <= '0;
            addr_q <= '0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            addr_q <= addr_d;
        end
    end

    assign addr       = addr_q;
    assign last_pixel = (x_q == X_MAX) && (y_q == Y_MAX);

endmodule

// File: rtl/frame_buffer_writer.sv
// Captures one raster-order frame per start into the column-major frame buffer,
// one registered write per accepted pixel, with framing error detection.
module frame_buffer_writer #(
    parameter int IMG_W  = vga_pkg::IMG_W,
    parameter int IMG_H  = vga_pkg::IMG_H,
    parameter int ADDR_W = vga_pkg::ADDR_W,
    parameter int DATA_W = vga_pkg::DATA_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    frame_buffer_writer_if.slave  bus,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  err_framing
);

    import vga_pkg::*;

    wr_state_e         state_q, state_d;
    logic              s_ready_q, s_ready_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              busy_q, busy_d;
    logic              frame_done_q, frame_done_d;
    logic              err_q, err_d;

    logic              hs_s;
    logic              clear_s;
    logic              last_pixel_s;
    logic [ADDR_W-1:0] pix_addr_s;

    // s_ready_q is high exactly in WRITE, so it alone qualifies the handshake.
    assign hs_s    = bus.s_valid & s_ready_q;
    assign clear_s = (state_q == ST_IDLE) & start;

    raster_addr_gen #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear_s),
        .step       (hs_s),
        .addr       (pix_addr_s),
        .last_pixel (last_pixel_s)
    );

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            s_ready_q    <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            s_ready_q    <= s_ready_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
        end
    end

    // Next state; an early s_last truncates the frame.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_WRITE;
                else       state_d = ST_IDLE;
            end
            ST_WRITE: begin
                if (hs_s && (last_pixel_s || bus.s_last)) state_d = ST_DONE;
                else                                      state_d = ST_WRITE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output next values, decoded from the next state so they register in step with it.
    always_comb begin
        s_ready_d    = (state_d == ST_WRITE);
        busy_d       = (state_d != ST_IDLE);
        frame_done_d = (state_d == ST_DONE);
        wr_en_d      = hs_s;
        if (hs_s) begin
            wr_addr_d = pix_addr_s;
            wr_data_d = bus.s_data;
        end else begin
            wr_addr_d = wr_addr_q;
            wr_data_d = wr_data_q;
        end
        if (clear_s) begin
            err_d = 1'b0;
        end else if (hs_s && (bus.s_last != last_pixel_s)) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    assign bus.s_ready = s_ready_q;
    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;
    assign err_framing = err_q;

endmodule

// File: tb/tb_frame_buffer_writer.sv
// Directed bench for frame_buffer_writer on a small 8x6 frame, checked every
// cycle against a pixel-index model of the writer.
module tb_frame_buffer_writer;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int N  = W * H;
    localparam int AW = 20;
    localparam int DW = 8;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic busy, frame_done, err_framing;

    frame_buffer_writer_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    frame_buffer_writer #(
        .IMG_W(W), .IMG_H(H), .ADDR_W(AW), .DATA_W(DW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .bus         (bus),
        .busy        (busy),
        .frame_done  (frame_done),
        .err_framing (err_framing)
    );

    always #5 clk = ~clk;

    int  n_cmp = 0;
    int  n_fail = 0;
    int  fd_cnt = 0;
    wr_t wlog[$];
    wr_t ref_log[$];

    // Model state: phase 0 idle, 1 accepting pixels, 2 done pulse.
    int            m_phase = 0;
    int            m_idx = 0;
    bit            m_err = 1'b0;
    bit            m_wr = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_data = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: check outputs at the falling edge, then advance the model.
    initial begin
        forever begin
            @(negedge clk);
            chk("s_ready",     32'(bus.s_ready),  32'(m_phase == 1));
            chk("busy",        32'(busy),         32'(m_phase != 0));
            chk("frame_done",  32'(frame_done),   32'(m_phase == 2));
            chk("err_framing", 32'(err_framing),  32'(m_err));
            chk("wr_en",       32'(bus.wr_en),    32'(m_wr));
            chk("wr_addr",     32'(bus.wr_addr),  32'(m_addr));
            chk("wr_data",     32'(bus.wr_data),  32'(m_data));
            if (bus.wr_en) wlog.push_back('{a: bus.wr_addr, d: bus.wr_data});
            if (frame_done) fd_cnt++;
            if (!rst_n) begin
                m_phase = 0; m_idx = 0; m_err = 1'b0; m_wr = 1'b0;
                m_addr = '0; m_data = '0;
            end else begin
                m_wr = 1'b0;
                case (m_phase)
                    0: if (start) begin m_phase = 1; m_idx = 0; m_err = 1'b0; end
                    1: if (bus.s_valid) begin
                        m_wr   = 1'b1;
                        m_addr = AW'((m_idx % W) * H + m_idx / W);
                        m_data = bus.s_data;
                        if (bus.s_last != (m_idx == N - 1)) m_err = 1'b1;
                        if (bus.s_last || m_idx == N - 1) m_phase = 2;
                        m_idx++;
                    end
                    default: m_phase = 0;
                endcase
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    // Send pixels 0..n_pix-1; s_last on index last_at, start also raised on index start_at.
    task automatic send_frame(input int n_pix, input int last_at, input bit gaps, input int start_at);
        int  i = 0;
        int  guard = 0;
        bit  hs;
        while (i < n_pix && guard < 4 * n_pix + 50) begin
            guard++;
            if (gaps && $urandom_range(1, 0) == 0) begin
                bus.s_valid = 1'b0;
                bus.s_last  = 1'b0;
                cyc();
            end else begin
                bus.s_valid = 1'b1;
                bus.s_data  = DW'(i);
                bus.s_last  = (i == last_at);
                start       = (i == start_at);
                hs          = bus.s_ready;
                cyc();
                start       = 1'b0;
                if (hs) i++;
            end
        end
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        chk("stream_timeout", 32'(i), 32'(n_pix));
    endtask

    initial begin
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_last  = 1'b0;
        repeat (2) cyc();
        rst_n = 1'b1;
        cyc();
        chk("reset_busy", 32'(busy), 32'd0);

        // Full frame without gaps.
        wlog.delete(); fd_cnt = 0;
        pulse_start();
        chk("ready_after_start", 32'(bus.s_ready), 32'd1);
        send_frame(N, N - 1, 1'b0, -1);
        repeat (3) cyc();
        chk("full_count",   32'(wlog.size()), 32'd48);
        chk("addr_x1_y0",   32'(wlog[1].a),   32'd6);
        chk("addr_x0_y1",   32'(wlog[8].a),   32'd1);
        chk("addr_final",   32'(wlog[47].a),  32'd47);
        chk("data_final",   32'(wlog[47].d),  32'd47);
        chk("full_fd_cnt",  32'(fd_cnt),      32'd1);
        chk("full_err",     32'(err_framing), 32'd0);
        ref_log = wlog;

        // Same frame with random valid gaps.
        wlog.delete(); fd_cnt = 0;
        pulse_start();
        send_frame(N, N - 1, 1'b1, -1);
        repeat (3) cyc();
        chk("gap_count", 32'(wlog.size()), 32'(ref_log.size()));
        for (int k = 0; k < N && k < wlog.size(); k++) begin
            chk("gap_addr", 32'(wlog[k].a), 32'(ref_log[k].a));
            chk("gap_data", 32'(wlog[k].d), 32'(ref_log[k].d));
        end

        // Early s_last on pixel 10 truncates the frame; upstream then keeps pushing.
        wlog.delete(); fd_cnt = 0;
        pulse_start();
        send_frame(11, 10, 1'b0, -1);
        bus.s_valid = 1'b1;
        repeat (5) cyc();
        bus.s_valid = 1'b0;
        chk("trunc_count", 32'(wlog.size()), 32'd11);
        chk("trunc_addr",  32'(wlog[10].a),  32'd13);
        chk("trunc_err",   32'(err_framing), 32'd1);
        chk("trunc_fd",    32'(fd_cnt),      32'd1);

        // start clears the error; final pixel without s_last sets it again.
        wlog.delete();
        pulse_start();
        chk("err_cleared", 32'(err_framing), 32'd0);
        send_frame(N, -1, 1'b0, -1);
        repeat (3) cyc();
        chk("nolast_count", 32'(wlog.size()), 32'd48);
        chk("nolast_err",   32'(err_framing), 32'd1);
        pulse_start();
        chk("err_cleared2", 32'(err_framing), 32'd0);
        send_frame(N, N - 1, 1'b0, -1);
        repeat (3) cyc();

        // Valid held in IDLE, then start pulsed mid-frame.
        bus.s_valid = 1'b1;
        repeat (3) cyc();
        chk("idle_ready", 32'(bus.s_ready), 32'd0);
        bus.s_valid = 1'b0;
        wlog.delete(); fd_cnt = 0;
        pulse_start();
        send_frame(N, N - 1, 1'b0, 20);
        repeat (3) cyc();
        chk("midstart_count", 32'(wlog.size()), 32'd48);
        for (int k = 0; k < N && k < wlog.size(); k++)
            chk("midstart_addr", 32'(wlog[k].a), 32'(ref_log[k].a));
        chk("midstart_fd", 32'(fd_cnt), 32'd1);

        // Reset mid-frame, then a fresh frame.
        pulse_start();
        send_frame(20, -1, 1'b0, -1);
        bus.s_valid = 1'b1;
        bus.s_data  = DW'(20);
        rst_n       = 1'b0;
        cyc();
        rst_n       = 1'b1;
        bus.s_valid = 1'b0;
        chk("rst_wr_en", 32'(bus.wr_en),   32'd0);
        chk("rst_addr",  32'(bus.wr_addr), 32'd0);
        chk("rst_busy",  32'(busy),        32'd0);
        wlog.delete();
        pulse_start();
        send_frame(N, N - 1, 1'b0, -1);
        repeat (3) cyc();
        chk("fresh_count", 32'(wlog.size()), 32'd48);
        chk("fresh_addr0", 32'(wlog[0].a),   32'd0);
        chk("fresh_data0", 32'(wlog[0].d),   32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
